// File: rtl/alu_operand_sequencer.sv
// rtl/alu_operand_sequencer.sv - switch-bus operand sequencer that feeds the registered ALU stage and captures its result
module alu_operand_sequencer #(
    parameter int bus_size       = 4,
    parameter int shamt_bus_size = 2,
    parameter int WAIT_CYCLES    = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [bus_size-1:0]       sw,
    input  logic                      enter,
    input  logic                      cancel,
    input  logic [bus_size-1:0]       result_in,
    output logic [bus_size-1:0]       data1,
    output logic [bus_size-1:0]       data2,
    output logic [2:0]                selector,
    output logic [shamt_bus_size:0]   shift,
    output logic [bus_size-1:0]       result,
    output logic                      result_valid,
    output logic                      busy,
    output logic [2:0]                step
);

    localparam int CNT_W = $clog2(WAIT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] S_A    = 3'd0;
    localparam logic [2:0] S_B    = 3'd1;
    localparam logic [2:0] S_OP   = 3'd2;
    localparam logic [2:0] S_SH   = 3'd3;
    localparam logic [2:0] S_RUN  = 3'd4;
    localparam logic [2:0] S_SHOW = 3'd5;

    logic [2:0]                state_q, state_d;
    logic                      enter_q_q, enter_q_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [bus_size-1:0]       data1_q, data1_d;
    logic [bus_size-1:0]       data2_q, data2_d;
    logic [2:0]                selector_q, selector_d;
    logic [shamt_bus_size:0]   shift_q, shift_d;
    logic [bus_size-1:0]       result_q, result_d;
    logic                      result_valid_q, result_valid_d;
    logic                      enter_edge;

    assign enter_edge = enter & ~enter_q_q;

    always_comb begin
        state_d        = state_q;
        enter_q_d      = enter;
        cnt_d          = cnt_q;
        data1_d        = data1_q;
        data2_d        = data2_q;
        selector_d     = selector_q;
        shift_d        = shift_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;

        // cancel overrides both a pending enter edge and the latency counter
        if (cancel) begin
            state_d        = S_A;
            cnt_d          = '0;
            data1_d        = '0;
            data2_d        = '0;
            selector_d     = '0;
            shift_d        = '0;
            result_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_A: if (enter_edge) begin
                    data1_d        = sw;
                    result_valid_d = 1'b0;
                    state_d        = S_B;
                end
                S_B: if (enter_edge) begin
                    data2_d = sw;
                    state_d = S_OP;
                end
                S_OP: if (enter_edge) begin
                    selector_d = sw[2:0];
                    state_d    = S_SH;
                end
                S_SH: if (enter_edge) begin
                    shift_d = sw[shamt_bus_size:0];
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
                S_RUN: begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        result_d       = result_in;
                        result_valid_d = 1'b1;
                        state_d        = S_SHOW;
                    end
                end
                S_SHOW: if (enter_edge) begin
                    state_d = S_A;
                end
                default: state_d = S_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_A;
            enter_q_q      <= 1'b1;
            cnt_q          <= '0;
            data1_q        <= '0;
            data2_q        <= '0;
            selector_q     <= '0;
            shift_q        <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            enter_q_q      <= enter_q_d;
            cnt_q          <= cnt_d;
            data1_q        <= data1_d;
            data2_q        <= data2_d;
            selector_q     <= selector_d;
            shift_q        <= shift_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign data1        = data1_q;
    assign data2        = data2_q;
    assign selector     = selector_q;
    assign shift        = shift_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign busy         = (state_q == S_RUN);
    assign step         = state_q;

endmodule
